parity_arb: RTL
===============

PARITY_ARB -- requirements
Module: parity_arb

Interface
- REQ-001: Parameter ODD_PARITY, default 0; 0 = even parity (out_parity = XOR of data bits), 1 = odd parity (out_parity = inverted XOR).
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- REQ-004: req0_valid  input  1  requester 0 has a byte to send.
- REQ-005: req0_data  input  8  requester 0 byte.
- REQ-006: req0_ready  output  1  requester 0 byte accepted this cycle.
- REQ-007: req1_valid  input  1  requester 1 has a byte to send.
- REQ-008: req1_data  input  8  requester 1 byte.
- REQ-009: req1_ready  output  1  requester 1 byte accepted this cycle.
- REQ-010: out_valid  output  1  output register holds a protected byte.
- REQ-011: out_data  output  8  held byte.
- REQ-012: out_parity  output  1  parity bit of out_data per ODD_PARITY.
- REQ-013: out_src  output  1  index of requester that supplied out_data.
- REQ-014: out_ready  input  1  downstream consumes held byte this cycle.
- REQ-015: xfer_count  output  8  number of completed output transfers, modulo 256.

Function
- REQ-016: Block shall time-share one 8-bit parity generator between two requesters through a single-entry output register.
- REQ-017: Handshake on every port: transfer occurs in a cycle where valid and ready are both 1 at the rising edge.
- REQ-018: Register shall be "free" when out_valid=0, or when out_valid=1 and out_ready=1 (same-cycle drain and refill allowed).
- REQ-019: reqN_ready shall be combinational: 1 only when register is free and requester N holds the grant; never 1 for both requesters in the same cycle.
- REQ-020: Grant rules: only one reqN_valid=1 -> grant N; both valid -> grant requester indicated by round-robin pointer; neither -> no grant.
- REQ-021: Round-robin pointer shall flip to the other requester after each accepted request; it shall not change on cycles without acceptance.
- REQ-022: On acceptance, next cycle: out_valid=1, out_data=granted byte, out_parity=^byte XOR ODD_PARITY, out_src=granted index; latency from acceptance to out_valid is exactly 1 cycle.
- REQ-023: While out_valid=1 and out_ready=0: out_data, out_parity, out_src shall be held stable; both reqN_ready=0.
- REQ-024: out_valid=1 and out_ready=1 with no request valid -> out_valid=0 next cycle.
- REQ-025: xfer_count shall increment by 1 on each cycle with out_valid=1 and out_ready=1; 255 wraps to 0.
- REQ-026: Sustained traffic with out_ready held 1 shall achieve one byte per cycle, alternating sources when both requesters stay valid.
- REQ-027: out_ready asserted while out_valid=0 shall have no effect.
- REQ-028: Requester inputs not accepted shall not alter any state.

Reset
- REQ-029: rst=1 at a rising edge -> out_valid=0, out_data=0x00, out_parity=ODD_PARITY, out_src=0, xfer_count=0, round-robin pointer favoring requester 0.
- REQ-030: While rst=1, req0_ready=0 and req1_ready=0.
- REQ-031: Reset mid-operation shall discard any held byte without counting it; first acceptance after reset follows REQ-020 with pointer at 0.

Verification
- REQ-032: Reset, then req0_valid=1 data=0x07, out_ready=1 -> req0_ready=1, next cycle out_data=0x07, out_parity=1 (ODD_PARITY=0), out_src=0, xfer_count=1 one cycle later.
- REQ-033: Both valid continuously (req0=0xA5, req1=0x3C), out_ready=1 -> out_src sequence 0,1,0,1 on consecutive cycles, out_parity=0 each, xfer_count=4 after four transfers.
- REQ-034: out_valid=1 with out_ready=0 for 5 cycles, both requests valid -> outputs stable, both ready=0; out_ready=1 -> drain and refill same cycle from the other requester.
- REQ-035: ODD_PARITY=1, data 0x00 -> out_parity=1; data 0xFF -> out_parity=1; data 0x01 -> out_parity=0.
- REQ-036: 256 transfers -> xfer_count returns to 0x00; reset asserted with out_valid=1 -> out_valid=0, xfer_count=0 next cycle, pointer back to requester 0.

Source files
------------

// File: rtl/parity_arb.sv
// Two-requester round-robin arbiter feeding one shared 8-bit parity generator
// through a single-entry output register with valid/ready handshakes.
module parity_arb #(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_parity,
    output logic       out_src,
    input  logic       out_ready,
    output logic [7:0] xfer_count
);

    localparam int NUM_REQ = 2;

    logic [NUM_REQ-1:0] req_valid;
    logic [7:0]         req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;

    logic       out_valid_reg,  out_valid_next;
    logic [7:0] out_data_reg,   out_data_next;
    logic       out_parity_reg, out_parity_next;
    logic       out_src_reg,    out_src_next;
    logic [7:0] xfer_count_reg, xfer_count_next;
    logic       rr_ptr_reg,     rr_ptr_next;

    logic       reg_free;
    logic       drain;
    logic       grant_valid;
    logic       grant_idx;
    logic       accept;
    logic [7:0] sel_data;
    logic       sel_parity;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // A same-cycle drain frees the slot, so refill can happen back-to-back.
    assign drain    = out_valid_reg && out_ready;
    assign reg_free = !out_valid_reg || out_ready;

    always_comb begin
        grant_valid = |req_valid;
        grant_idx   = 1'b0;
        case (req_valid)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = rr_ptr_reg;
            default: grant_idx = 1'b0;
        endcase
    end

    // Ready is one-hot by construction: only the granted index can match.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && reg_free && grant_valid &&
                                   (grant_idx == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign accept     = |req_ready;

    // The single parity generator, fed by whichever requester holds the grant.
    assign sel_data   = req_data[grant_idx];
    assign sel_parity = (^sel_data) ^ ODD_PARITY;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_parity_next = out_parity_reg;
        out_src_next    = out_src_reg;
        xfer_count_next = xfer_count_reg;
        rr_ptr_next     = rr_ptr_reg;

        if (drain) begin
            xfer_count_next = xfer_count_reg + 8'd1;
            out_valid_next  = 1'b0;
        end

        if (accept) begin
            out_valid_next  = 1'b1;
            out_data_next   = sel_data;
            out_parity_next = sel_parity;
            out_src_next    = grant_idx;
            rr_ptr_next     = ~grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 8'h00;
            out_parity_reg <= ODD_PARITY;
            out_src_reg    <= 1'b0;
            xfer_count_reg <= 8'h00;
            rr_ptr_reg     <= 1'b0;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_parity_reg <= out_parity_next;
            out_src_reg    <= out_src_next;
            xfer_count_reg <= xfer_count_next;
            rr_ptr_reg     <= rr_ptr_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_parity = out_parity_reg;
    assign out_src    = out_src_reg;
    assign xfer_count = xfer_count_reg;

endmodule
